// File: rtl/battle_pkg.sv
// battle_pkg: shared types and constants for the battle engine.
//   battle_state_e : turn FSM states
//   TRAINER_*      : encoding of the active_trainer output
//   LFSR_SEED/TAPS : AI move generator seed and feedback mask
//   lfsr_next()    : one shift step of the AI move generator
package battle_pkg;

    typedef enum logic [3:0] {
        LOAD,
        P_CALC,
        AI_UPD,
        AI_FAINT,
        AI_CALC,
        P_UPD,
        P_FAINT,
        VICTORY,
        LOSS
    } battle_state_e;

    localparam logic TRAINER_PLAYER = 1'b0;
    localparam logic TRAINER_AI     = 1'b1;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/battle_lfsr.sv
// battle_lfsr: free-running 8-bit Fibonacci LFSR used to pick AI moves.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, loads LFSR_SEED
//   q       : current LFSR state
module battle_lfsr
    import battle_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/battle_engine.sv
// battle_engine: turn FSM for a PARTY_N-vs-PARTY_N battle with per-slot HP.
//   clk, reset_n        : clock, asynchronous active-low reset
//   go                  : advance / restart strobe (LOAD, VICTORY, LOSS only)
//   p_move              : player move, latched when a turn starts
//   dmg_valid, dmg      : damage calculator result (accepted in CALC states)
//   calc_req            : damage request, held until dmg_valid
//   active_trainer      : 0 player attacking, 1 AI attacking
//   target              : 1 AI Pokemon targeted, 0 player Pokemon targeted
//   move_sel            : move forwarded to the calculator
//   apply_damage        : one-cycle pulse in each HP-update cycle
//   p_slot, ai_slot     : active party slot per side
//   p_hp, ai_hp         : HP of the active slot per side
//   turn_cnt            : completed turns, saturating
//   victory, loss       : terminal flags
module battle_engine
    import battle_pkg::*;
#(
    parameter int unsigned HP_W    = 8,
    parameter int unsigned DMG_W   = 8,
    parameter int unsigned PARTY_N = 3,
    parameter int unsigned INIT_HP = 100,
    parameter int unsigned TURN_W  = 8,
    localparam int unsigned SLOT_W = (PARTY_N > 1) ? $clog2(PARTY_N) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [1:0]        p_move,
    input  logic              dmg_valid,
    input  logic [DMG_W-1:0]  dmg,
    output logic              calc_req,
    output logic              active_trainer,
    output logic              target,
    output logic [1:0]        move_sel,
    output logic              apply_damage,
    output logic [SLOT_W-1:0] p_slot,
    output logic [SLOT_W-1:0] ai_slot,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic [TURN_W-1:0] turn_cnt,
    output logic              victory,
    output logic              loss
);

    localparam int unsigned       CMP_W     = (HP_W > DMG_W) ? HP_W : DMG_W;
    localparam logic [HP_W-1:0]   HP_FULL   = HP_W'(INIT_HP);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PARTY_N - 1);
    localparam logic [TURN_W-1:0] TURN_MAX  = '1;

    battle_state_e     state_q, state_d;
    logic [HP_W-1:0]   hp_p_q  [PARTY_N];
    logic [HP_W-1:0]   hp_p_d  [PARTY_N];
    logic [HP_W-1:0]   hp_ai_q [PARTY_N];
    logic [HP_W-1:0]   hp_ai_d [PARTY_N];
    logic [SLOT_W-1:0] p_slot_q, p_slot_d;
    logic [SLOT_W-1:0] ai_slot_q, ai_slot_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [DMG_W-1:0]  dmg_q, dmg_d;
    logic [1:0]        move_sel_q, move_sel_d;
    logic              calc_req_q, calc_req_d;
    logic              active_q, active_d;
    logic              target_q, target_d;
    logic              apply_q, apply_d;
    logic              victory_q, victory_d;
    logic              loss_q, loss_d;

    logic [7:0]        lfsr_val;
    logic              unused_lfsr_bits;
    logic [HP_W-1:0]   p_hp_cur, ai_hp_cur;
    logic [HP_W-1:0]   upd_hp;
    logic [TURN_W-1:0] turn_inc;

    battle_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_val)
    );

    // Only the low two bits select a move.
    assign unused_lfsr_bits = ^lfsr_val[7:2];

    // Saturating subtract; both operands zero-extended to the wider width
    // so a large dmg never wraps a small HP.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0]  hp,
                                                 input logic [DMG_W-1:0] d);
        logic [CMP_W-1:0] hp_x;
        logic [CMP_W-1:0] d_x;
        hp_x = CMP_W'(hp);
        d_x  = CMP_W'(d);
        if (d_x >= hp_x) begin
            return '0;
        end
        return HP_W'(hp_x - d_x);
    endfunction

    // Active-slot read mux.
    always_comb begin
        p_hp_cur  = '0;
        ai_hp_cur = '0;
        for (int unsigned i = 0; i < PARTY_N; i++) begin
            if (SLOT_W'(i) == p_slot_q) begin
                p_hp_cur = hp_p_q[i];
            end
            if (SLOT_W'(i) == ai_slot_q) begin
                ai_hp_cur = hp_ai_q[i];
            end
        end
    end

    assign turn_inc = (turn_q == TURN_MAX) ? turn_q : turn_q + TURN_W'(1);

    always_comb begin
        state_d    = state_q;
        hp_p_d     = hp_p_q;
        hp_ai_d    = hp_ai_q;
        p_slot_d   = p_slot_q;
        ai_slot_d  = ai_slot_q;
        turn_d     = turn_q;
        dmg_d      = dmg_q;
        move_sel_d = move_sel_q;
        upd_hp     = '0;

        case (state_q)
            LOAD: begin
                if (go) begin
                    move_sel_d = p_move;
                    state_d    = P_CALC;
                end
            end
            P_CALC: begin
                if (dmg_valid) begin
                    dmg_d   = dmg;
                    state_d = AI_UPD;
                end
            end
            AI_UPD: begin
                upd_hp = sat_sub(ai_hp_cur, dmg_q);
                for (int unsigned i = 0; i < PARTY_N; i++) begin
                    if (SLOT_W'(i) == ai_slot_q) begin
                        hp_ai_d[i] = upd_hp;
                    end
                end
                if (upd_hp == '0) begin
                    state_d = AI_FAINT;
                end else begin
                    // AI move is sampled on the edge entering AI_CALC.
                    move_sel_d = lfsr_val[1:0];
                    state_d    = AI_CALC;
                end
            end
            AI_FAINT: begin
                if (ai_slot_q == LAST_SLOT) begin
                    state_d = VICTORY;
                end else begin
                    ai_slot_d = ai_slot_q + SLOT_W'(1);
                    turn_d    = turn_inc;
                    state_d   = LOAD;
                end
            end
            AI_CALC: begin
                if (dmg_valid) begin
                    dmg_d   = dmg;
                    state_d = P_UPD;
                end
            end
            P_UPD: begin
                upd_hp = sat_sub(p_hp_cur, dmg_q);
                for (int unsigned i = 0; i < PARTY_N; i++) begin
                    if (SLOT_W'(i) == p_slot_q) begin
                        hp_p_d[i] = upd_hp;
                    end
                end
                if (upd_hp == '0) begin
                    state_d = P_FAINT;
                end else begin
                    turn_d  = turn_inc;
                    state_d = LOAD;
                end
            end
            P_FAINT: begin
                if (p_slot_q == LAST_SLOT) begin
                    state_d = LOSS;
                end else begin
                    p_slot_d = p_slot_q + SLOT_W'(1);
                    turn_d   = turn_inc;
                    state_d  = LOAD;
                end
            end
            VICTORY, LOSS: begin
                if (go) begin
                    for (int unsigned i = 0; i < PARTY_N; i++) begin
                        hp_p_d[i]  = HP_FULL;
                        hp_ai_d[i] = HP_FULL;
                    end
                    p_slot_d  = '0;
                    ai_slot_d = '0;
                    turn_d    = '0;
                    state_d   = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Outputs are registered from the next state so each one is valid
        // for exactly the cycle its state is current.
        calc_req_d = (state_d == P_CALC) || (state_d == AI_CALC);
        active_d   = (state_d == AI_CALC) ? TRAINER_AI : TRAINER_PLAYER;
        target_d   = (state_d == P_CALC) || (state_d == AI_UPD);
        apply_d    = (state_d == AI_UPD) || (state_d == P_UPD);
        victory_d  = (state_d == VICTORY);
        loss_d     = (state_d == LOSS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            for (int unsigned i = 0; i < PARTY_N; i++) begin
                hp_p_q[i]  <= HP_FULL;
                hp_ai_q[i] <= HP_FULL;
            end
            p_slot_q   <= '0;
            ai_slot_q  <= '0;
            turn_q     <= '0;
            dmg_q      <= '0;
            move_sel_q <= '0;
            calc_req_q <= 1'b0;
            active_q   <= 1'b0;
            target_q   <= 1'b0;
            apply_q    <= 1'b0;
            victory_q  <= 1'b0;
            loss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_p_q     <= hp_p_d;
            hp_ai_q    <= hp_ai_d;
            p_slot_q   <= p_slot_d;
            ai_slot_q  <= ai_slot_d;
            turn_q     <= turn_d;
            dmg_q      <= dmg_d;
            move_sel_q <= move_sel_d;
            calc_req_q <= calc_req_d;
            active_q   <= active_d;
            target_q   <= target_d;
            apply_q    <= apply_d;
            victory_q  <= victory_d;
            loss_q     <= loss_d;
        end
    end

    assign calc_req       = calc_req_q;
    assign active_trainer = active_q;
    assign target         = target_q;
    assign move_sel       = move_sel_q;
    assign apply_damage   = apply_q;
    assign p_slot         = p_slot_q;
    assign ai_slot        = ai_slot_q;
    assign p_hp           = p_hp_cur;
    assign ai_hp          = ai_hp_cur;
    assign turn_cnt       = turn_q;
    assign victory        = victory_q;
    assign loss           = loss_q;

endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine: self-checking bench for battle_engine.
//   dut  : PARTY_N=3, main target of all sequences
//   dut1 : PARTY_N=1, shares inputs; checked for the single-Pokemon win
module tb_battle_engine;

    localparam int PN   = 3;
    localparam int INIT = 100;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       go        = 1'b0;
    logic [1:0] p_move    = 2'd0;
    logic       dmg_valid = 1'b0;
    logic [7:0] dmg       = 8'd0;

    logic       calc_req, active_trainer, target, apply_damage, victory, loss;
    logic [1:0] move_sel, p_slot, ai_slot;
    logic [7:0] p_hp, ai_hp, turn_cnt;

    logic       o1_calc_req, o1_active, o1_target, o1_apply, o1_victory, o1_loss;
    logic [1:0] o1_move_sel;
    logic [0:0] o1_p_slot, o1_ai_slot;
    logic [7:0] o1_p_hp, o1_ai_hp, o1_turn;

    always #5 clk = ~clk;

    battle_engine #(
        .HP_W(8), .DMG_W(8), .PARTY_N(3), .INIT_HP(100), .TURN_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .p_move(p_move),
        .dmg_valid(dmg_valid), .dmg(dmg), .calc_req(calc_req),
        .active_trainer(active_trainer), .target(target), .move_sel(move_sel),
        .apply_damage(apply_damage), .p_slot(p_slot), .ai_slot(ai_slot),
        .p_hp(p_hp), .ai_hp(ai_hp), .turn_cnt(turn_cnt),
        .victory(victory), .loss(loss)
    );

    battle_engine #(
        .HP_W(8), .DMG_W(8), .PARTY_N(1), .INIT_HP(100), .TURN_W(8)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .go(go), .p_move(p_move),
        .dmg_valid(dmg_valid), .dmg(dmg), .calc_req(o1_calc_req),
        .active_trainer(o1_active), .target(o1_target), .move_sel(o1_move_sel),
        .apply_damage(o1_apply), .p_slot(o1_p_slot), .ai_slot(o1_ai_slot),
        .p_hp(o1_p_hp), .ai_hp(o1_ai_hp), .turn_cnt(o1_turn),
        .victory(o1_victory), .loss(o1_loss)
    );

    // ---------------- reference model ----------------
    int  total = 0;
    int  bad   = 0;
    int  p_hp_m [PN];
    int  ai_hp_m[PN];
    int  p_slot_m, ai_slot_m, turn_m;
    bit  vic_m, loss_m;
    logic [7:0] lfsr_m;

    // Polynomial x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 8'hA5;
        else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic int sat(input int hp, input int d);
        return (d >= hp) ? 0 : hp - d;
    endfunction

    function automatic int tinc(input int t);
        return (t < 255) ? t + 1 : 255;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < PN; i++) begin
            p_hp_m[i]  = INIT;
            ai_hp_m[i] = INIT;
        end
        p_slot_m  = 0;
        ai_slot_m = 0;
        turn_m    = 0;
        vic_m     = 0;
        loss_m    = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.p_hp", tag),     int'(p_hp),     p_hp_m[p_slot_m]);
        chk($sformatf("%s.ai_hp", tag),    int'(ai_hp),    ai_hp_m[ai_slot_m]);
        chk($sformatf("%s.p_slot", tag),   int'(p_slot),   p_slot_m);
        chk($sformatf("%s.ai_slot", tag),  int'(ai_slot),  ai_slot_m);
        chk($sformatf("%s.turn_cnt", tag), int'(turn_cnt), turn_m);
        chk($sformatf("%s.victory", tag),  int'(victory),  int'(vic_m));
        chk($sformatf("%s.loss", tag),     int'(loss),     int'(loss_m));
    endtask

    // One full turn from LOAD. Inputs are driven and outputs sampled on
    // falling edges; delays are cycles of calculator latency.
    task automatic run_turn(input logic [1:0] m, input int pd, input int pdl,
                            input int ad, input int adl, input bit stray);
        logic [7:0] lf;
        int e;
        if (stray) begin
            dmg_valid = 1'b1; dmg = 8'hFF;
            @(negedge clk);
            chk("stray_load.calc_req", int'(calc_req), 0);
            chk("stray_load.ai_hp", int'(ai_hp), ai_hp_m[ai_slot_m]);
            dmg_valid = 1'b0;
        end
        go = 1'b1; p_move = m;
        @(negedge clk);
        go = 1'b0;
        chk("p_calc.calc_req", int'(calc_req), 1);
        chk("p_calc.active", int'(active_trainer), 0);
        chk("p_calc.target", int'(target), 1);
        chk("p_calc.move_sel", int'(move_sel), int'(m));
        for (int i = 0; i < pdl; i++) begin
            go = stray;
            @(negedge clk);
            chk("p_wait.calc_req", int'(calc_req), 1);
            chk("p_wait.apply", int'(apply_damage), 0);
        end
        go = 1'b0; dmg_valid = 1'b1; dmg = 8'(pd);
        @(negedge clk);
        chk("ai_upd.apply", int'(apply_damage), 1);
        chk("ai_upd.calc_req", int'(calc_req), 0);
        chk("ai_upd.target", int'(target), 1);
        lf = lfsr_m;
        e = sat(ai_hp_m[ai_slot_m], pd);
        ai_hp_m[ai_slot_m] = e;
        dmg_valid = stray; dmg = 8'hFF;
        @(negedge clk);
        dmg_valid = 1'b0;
        chk("post_ai_upd.apply", int'(apply_damage), 0);
        chk("post_ai_upd.ai_hp", int'(ai_hp), e);
        if (e == 0) begin
            chk("ai_faint.calc_req", int'(calc_req), 0);
            @(negedge clk);
            if (ai_slot_m == PN - 1) begin
                vic_m = 1;
            end else begin
                ai_slot_m++;
                turn_m = tinc(turn_m);
            end
            chk("ai_faint_exit.calc_req", int'(calc_req), 0);
            check_all("ai_faint_exit");
        end else begin
            chk("ai_calc.calc_req", int'(calc_req), 1);
            chk("ai_calc.active", int'(active_trainer), 1);
            chk("ai_calc.target", int'(target), 0);
            chk("ai_calc.move_sel", int'(move_sel), int'(lf[1:0]));
            for (int i = 0; i < adl; i++) begin
                go = stray;
                @(negedge clk);
                chk("ai_wait.calc_req", int'(calc_req), 1);
                chk("ai_wait.move_sel", int'(move_sel), int'(lf[1:0]));
            end
            go = 1'b0; dmg_valid = 1'b1; dmg = 8'(ad);
            @(negedge clk);
            chk("p_upd.apply", int'(apply_damage), 1);
            chk("p_upd.calc_req", int'(calc_req), 0);
            e = sat(p_hp_m[p_slot_m], ad);
            p_hp_m[p_slot_m] = e;
            dmg_valid = 1'b0;
            @(negedge clk);
            chk("post_p_upd.apply", int'(apply_damage), 0);
            chk("post_p_upd.p_hp", int'(p_hp), e);
            if (e == 0) begin
                chk("p_faint.calc_req", int'(calc_req), 0);
                chk("p_faint.loss", int'(loss), 0);
                @(negedge clk);
                if (p_slot_m == PN - 1) begin
                    loss_m = 1;
                end else begin
                    p_slot_m++;
                    turn_m = tinc(turn_m);
                end
            end else begin
                turn_m = tinc(turn_m);
            end
            check_all("turn_end");
        end
    endtask

    task automatic restart();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        mdl_reset();
        check_all("restart");
        chk("restart.calc_req", int'(calc_req), 0);
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] pm;
        int         pd, pdl, ad, adl;
        bit         stray;
        int         e_ai, e_p, e_ais, e_ps, e_turn;
        bit         e_vic, e_loss;
    } vec_t;

    vec_t vt[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //        rst pm  pd  pdl ad  adl st   ai  p   ais ps turn v  l
        vt[0] = '{0, 2'd1, 60,  0, 10,  0, 0,  40, 90, 0, 0, 1, 0, 0};
        vt[1] = '{0, 2'd2, 40,  0,  0,  0, 0, 100, 90, 1, 0, 2, 0, 0};
        vt[2] = '{0, 2'd3, 70,  7,  5,  7, 0,  30, 85, 1, 0, 3, 0, 0};
        vt[3] = '{0, 2'd0, 255, 0,  0,  0, 0, 100, 85, 2, 0, 4, 0, 0};
        vt[4] = '{0, 2'd1, 0,   2,  0,  1, 1, 100, 85, 2, 0, 5, 0, 0};
        vt[5] = '{0, 2'd2, 100, 0,  0,  0, 0,   0, 85, 2, 0, 5, 1, 0};
        vt[6] = '{1, 2'd0, 0,   0, 100, 0, 0, 100,100, 0, 1, 1, 0, 0};
        vt[7] = '{0, 2'd1, 0,   0, 100, 0, 0, 100,100, 0, 2, 2, 0, 0};
        vt[8] = '{0, 2'd2, 0,   0, 150, 3, 0, 100,  0, 0, 2, 2, 0, 1};
        vt[9] = '{1, 2'd3, 5,   1,  5,  1, 1,  95, 95, 0, 0, 1, 0, 0};

        mdl_reset();
        repeat (3) @(negedge clk);
        chk("reset.calc_req", int'(calc_req), 0);
        chk("reset.active", int'(active_trainer), 0);
        chk("reset.target", int'(target), 0);
        chk("reset.apply", int'(apply_damage), 0);
        chk("reset.move_sel", int'(move_sel), 0);
        check_all("reset");
        chk("reset1.p_hp", int'(o1_p_hp), 100);
        chk("reset1.victory", int'(o1_victory), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle.calc_req", int'(calc_req), 0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].rst) restart();
            run_turn(vt[i].pm, vt[i].pd, vt[i].pdl, vt[i].ad, vt[i].adl, vt[i].stray);
            chk($sformatf("vec%0d.ai_hp", i),    int'(ai_hp),    vt[i].e_ai);
            chk($sformatf("vec%0d.p_hp", i),     int'(p_hp),     vt[i].e_p);
            chk($sformatf("vec%0d.ai_slot", i),  int'(ai_slot),  vt[i].e_ais);
            chk($sformatf("vec%0d.p_slot", i),   int'(p_slot),   vt[i].e_ps);
            chk($sformatf("vec%0d.turn_cnt", i), int'(turn_cnt), vt[i].e_turn);
            chk($sformatf("vec%0d.victory", i),  int'(victory),  int'(vt[i].e_vic));
            chk($sformatf("vec%0d.loss", i),     int'(loss),     int'(vt[i].e_loss));
            if (i == 1) begin
                chk("party1_win.victory", int'(o1_victory), 1);
                chk("party1_win.p_hp", int'(o1_p_hp), 90);
                chk("party1_win.ai_hp", int'(o1_ai_hp), 0);
                chk("party1_win.turn_cnt", int'(o1_turn), 1);
            end
            if (vt[i].e_vic || vt[i].e_loss) begin
                repeat (2) @(negedge clk);
                chk($sformatf("vec%0d.hold_victory", i), int'(victory), int'(vt[i].e_vic));
                chk($sformatf("vec%0d.hold_loss", i), int'(loss), int'(vt[i].e_loss));
                chk($sformatf("vec%0d.hold_calc_req", i), int'(calc_req), 0);
            end
        end

        // Randomized turns against the model.
        for (int n = 0; n < 80; n++) begin
            int pd, ad;
            if (vic_m || loss_m) restart();
            pd = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 60));
            ad = int'($urandom_range(0, 45));
            run_turn(2'($urandom_range(0, 3)), pd, int'($urandom_range(0, 3)),
                     ad, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        if (vic_m || loss_m) restart();

        // Zero-damage turns drive the turn counter into saturation.
        for (int n = 0; n < 260; n++) begin
            run_turn(2'd0, 0, 0, 0, 0, 1'b0);
        end
        chk("turn_sat", int'(turn_cnt), 255);
        run_turn(2'd1, 10, 0, 10, 0, 1'b0);
        chk("turn_sat_hold", int'(turn_cnt), 255);

        // Asynchronous reset while in P_CALC.
        go = 1'b1; p_move = 2'd3;
        @(negedge clk);
        go = 1'b0;
        chk("pre_reset.calc_req", int'(calc_req), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset.calc_req", int'(calc_req), 0);
        chk("async_reset.target", int'(target), 0);
        chk("async_reset.move_sel", int'(move_sel), 0);
        chk("async_reset.p_hp", int'(p_hp), 100);
        chk("async_reset.ai_hp", int'(ai_hp), 100);
        chk("async_reset.turn_cnt", int'(turn_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mdl_reset();
        check_all("post_reset");
        run_turn(2'd2, 20, 1, 20, 1, 1'b0);
        run_turn(2'd1, 30, 0, 30, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/battle_engine.md
# battle_engine

Parametrised successor to the single-Pokémon battle controller. It combines the turn FSM with per-slot HP storage for a party of `PARTY_N` Pokémon per side. It issues damage requests to the external damage calculator over a req/valid handshake, applies saturating damage, switches in the next Pokémon when one faints, and declares victory or loss when a whole party is exhausted. The AI move is chosen internally by an LFSR. The block sits between the board I/O (`go`, player move switches) and the damage-calculation datapath.

## Interface
- `HP_W`, 8: HP register width.
- `DMG_W`, 8: damage input width.
- `PARTY_N`, 3: Pokémon per side (≥1).
- `INIT_HP`, 100: HP of every slot after reset or restart (< 2^HP_W).
- `TURN_W`, 8: turn counter width.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: advance/confirm strobe, sampled every rising edge.
- `p_move` in 2: player move select.
- `dmg_valid` in 1: damage result valid.
- `dmg` in DMG_W: damage amount.
- `calc_req` out 1: damage request, held until `dmg_valid`.
- `active_trainer` out 1: 0 = player attacking, 1 = AI attacking.
- `target` out 1: 1 = AI Pokémon is the target, 0 = player Pokémon is the target.
- `move_sel` out 2: move forwarded to the calculator.
- `apply_damage` out 1: 1-cycle pulse in the HP-update cycle.
- `p_slot`, `ai_slot` out $clog2(PARTY_N) (min 1): active slot index for each side.
- `p_hp`, `ai_hp` out HP_W: HP of the active slot on each side.
- `turn_cnt` out TURN_W: completed turns.
- `victory`, `loss` out 1: terminal flags.

## Operation
- **Reset values.** State LOAD. All HP slots = INIT_HP. Slots = 0. `turn_cnt` = 0. LFSR = 8'hA5. All 1-bit outputs = 0. `move_sel` = 0.
- **LFSR.** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle and is never reset except by `reset_n`.
- **LOAD.** On `go`, latch `p_move`, then go to P_CALC.
- **P_CALC.** Outputs: `calc_req`=1, `active_trainer`=0, `target`=1, `move_sel`=latched `p_move`. On `dmg_valid`, latch `dmg`, then go to AI_UPD. Without `dmg_valid`, stay.
- **AI_UPD** (one cycle). Outputs: `apply_damage`=1, `target`=1. Write `hp_ai[ai_slot]` = the saturating difference: 0 if dmg ≥ HP, else HP − dmg. Compare with zero-extension to max(HP_W, DMG_W). If the result is 0, go to AI_FAINT; otherwise go to AI_CALC.
- **AI_FAINT** (one cycle). If `ai_slot` = PARTY_N−1, go to VICTORY. Otherwise increment `ai_slot`, increment `turn_cnt`, and go to LOAD. A fainted Pokémon does not attack.
- **AI_CALC.** Outputs: `calc_req`=1, `active_trainer`=1, `target`=0. Latch `move_sel` = LFSR[1:0] on entry and hold it. On `dmg_valid`, go to P_UPD.
- **P_UPD** (one cycle). Same as AI_UPD, applied to `hp_p[p_slot]`. If the result is 0, go to P_FAINT. Otherwise increment `turn_cnt` and go to LOAD.
- **P_FAINT.** If `p_slot` is the last slot, go to LOSS. Otherwise increment `p_slot`, increment `turn_cnt`, and go to LOAD.
- **VICTORY / LOSS.** `victory` or `loss` is held at 1. On `go`, restart:
  - all HP = INIT_HP, slots = 0, `turn_cnt` = 0;
  - go to LOAD;
  - the LFSR is not reset.
- **Boundary rules.**
  - `turn_cnt` saturates at all-ones.
  - `dmg_valid` outside the CALC states is ignored.
  - `go` outside LOAD/VICTORY/LOSS is ignored.
  - `dmg` = 0 leaves HP unchanged and the battle continues.
  - Fainted slots keep HP = 0.
  - Asserting `reset_n` mid-turn aborts immediately to the reset values.

## Timing
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- `go` high at edge t in LOAD: `calc_req` is high from cycle t+1.
- `dmg_valid` at edge u: `calc_req` drops at u+1, and `apply_damage` is high during cycle u+1. The new HP is visible on `p_hp`/`ai_hp` at u+2.
- Minimum turn with zero calculator latency: LOAD → P_CALC → AI_UPD → AI_CALC → P_UPD → LOAD, which is 5 cycles after `go`.
- A faint adds one cycle (the FAINT state).
- `victory`/`loss` assert one cycle after the FAINT state.

## Structure
- **`battle_pkg`:**
  - state enum (LOAD, P_CALC, AI_UPD, AI_FAINT, AI_CALC, P_UPD, P_FAINT, VICTORY, LOSS);
  - `TRAINER_PLAYER`=0 / `TRAINER_AI`=1;
  - LFSR seed 8'hA5 and tap mask.
- **Sub-module `battle_lfsr`:** 8-bit free-running LFSR with `clk`, `reset_n`, and `q[7:0]`.
- **HP storage:** two PARTY_N×HP_W register arrays inside `battle_engine`.

## Test plan
- **Player win.** PARTY_N=1, INIT_HP=100. Player damage of 60 and 40 with AI damage of 10 → `ai_hp` 40 then 0, then VICTORY. `victory`=1, `p_hp`=90, `turn_cnt`=1.
- **Saturation.** `ai_hp`=30, `dmg`=8'hFF → `ai_hp`=0, no wrap, AI_FAINT entered.
- **Party switch.** PARTY_N=3, AI slot 0 KO'd → `ai_slot`=1, `ai_hp`=100, no AI attack that turn, `turn_cnt`+1. Knocking out all three slots → `victory`.
- **Player loss.** AI damage of 100 on each player slot → `p_slot` steps 0, 1, 2, then LOSS. `loss`=1, `turn_cnt`=2.
- **Handshake.** `dmg_valid` delayed 7 cycles → `calc_req` held for 7 cycles, `apply_damage` exactly 1 cycle. Stray `dmg_valid` and `go` in LOAD/UPD states are ignored. LFSR-derived `move_sel` matches the reference model after reset.
- **Reset and restart.** Assert `reset_n` low mid P_CALC → all outputs return to reset values asynchronously. `go` in VICTORY → all HP=100, slots 0, `turn_cnt`=0, state LOAD.
